// File: rtl/unidir_disjoint_switch_box.sv
// Unidirectional disjoint switch box: each output track k on every side picks track k of one
// of the three other sides (or constant 0) using a 2-bit code taken from configuration byte k.
// Configuration is either passed straight through from c (cset=1, also captured each clk) or
// held in cfg_q (cset=0).
// Optional build macro DSB_OUT_REG_EN: when defined, every output is registered (1-cycle
// latency, async clear); when undefined, outputs are purely combinational.
module unidir_disjoint_switch_box #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cset,
  input  logic [8*W-1:0] c,
  input  logic [W-1:0]   north_in,
  input  logic [W-1:0]   east_in,
  input  logic [W-1:0]   south_in,
  input  logic [W-1:0]   west_in,
  output logic [W-1:0]   north_out,
  output logic [W-1:0]   east_out,
  output logic [W-1:0]   south_out,
  output logic [W-1:0]   west_out
);

  logic [8*W-1:0] cfg_q;
  logic [8*W-1:0] cfg;
  logic [W-1:0]   north_mux;
  logic [W-1:0]   east_mux;
  logic [W-1:0]   south_mux;
  logic [W-1:0]   west_mux;

  // Code 0/1/2 pick a/b/c; code 3 parks the track at 0. A case keeps unselected X off the output.
  function automatic logic pick(logic [1:0] code, logic a, logic b, logic cc);
    logic r;
    unique case (code)
      2'd0:    r = a;
      2'd1:    r = b;
      2'd2:    r = cc;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Configuration register: async clear, captures c whenever cset is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q <= '0;
    end else if (cset) begin
      cfg_q <= c;
    end
  end

  // Transparent mode lets c reach the muxes without a clock, even while in reset.
  assign cfg = cset ? c : cfg_q;

  // Per-track muxes; track indices never cross and no side feeds itself.
  always_comb begin
    north_mux = '0;
    east_mux  = '0;
    south_mux = '0;
    west_mux  = '0;
    for (int k = 0; k < W; k++) begin
      north_mux[k] = pick(cfg[8*k+0 +: 2], east_in[k],  south_in[k], west_in[k]);
      east_mux[k]  = pick(cfg[8*k+2 +: 2], south_in[k], west_in[k],  north_in[k]);
      south_mux[k] = pick(cfg[8*k+4 +: 2], west_in[k],  north_in[k], east_in[k]);
      west_mux[k]  = pick(cfg[8*k+6 +: 2], north_in[k], east_in[k],  south_in[k]);
    end
  end

`ifdef DSB_OUT_REG_EN
  logic [W-1:0] north_q;
  logic [W-1:0] east_q;
  logic [W-1:0] south_q;
  logic [W-1:0] west_q;

  // Output flops: one cycle of latency, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      north_q <= '0;
      east_q  <= '0;
      south_q <= '0;
      west_q  <= '0;
    end else begin
      north_q <= north_mux;
      east_q  <= east_mux;
      south_q <= south_mux;
      west_q  <= west_mux;
    end
  end

  assign north_out = north_q;
  assign east_out  = east_q;
  assign south_out = south_q;
  assign west_out  = west_q;
`else
  assign north_out = north_mux;
  assign east_out  = east_mux;
  assign south_out = south_mux;
  assign west_out  = west_mux;
`endif

endmodule

// File: tb/tb_unidir_disjoint_switch_box.sv
// Scoreboard bench for unidir_disjoint_switch_box (default combinational build, W=8).
// The driver applies one vector per cycle shortly after posedge and queues the expected
// outputs; the monitor pops and compares on each negedge.
module tb_unidir_disjoint_switch_box;

  localparam int unsigned W = 8;

  logic           clk;
  logic           rst;
  logic           cset;
  logic [8*W-1:0] c;
  logic [W-1:0]   ni, ei, si, wi;
  logic [W-1:0]   no, eo, so, wo;

  typedef struct {
    string      nm;
    logic [7:0] no;
    logic [7:0] eo;
    logic [7:0] so;
    logic [7:0] wo;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 0;

  unidir_disjoint_switch_box #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cset      (cset),
    .c         (c),
    .north_in  (ni),
    .east_in   (ei),
    .south_in  (si),
    .west_in   (wi),
    .north_out (no),
    .east_out  (eo),
    .south_out (so),
    .west_out  (wo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sides N=0,E=1,S=2,W=3; output side o with code m<3 takes side (o+1+m) mod 4.
  function automatic exp_t model(string nm, logic [63:0] cc, logic [7:0] n, logic [7:0] e,
                                 logic [7:0] s, logic [7:0] w);
    logic [7:0] src[4];
    logic [7:0] res[4];
    exp_t       x;
    src[0] = n; src[1] = e; src[2] = s; src[3] = w;
    for (int os = 0; os < 4; os++) begin
      for (int k = 0; k < 8; k++) begin
        logic [1:0] code;
        code = cc[8*k + 2*os +: 2];
        res[os][k] = (code == 2'd3) ? 1'b0 : src[(os + 1 + int'(code)) % 4][k];
      end
    end
    x.nm = nm; x.no = res[0]; x.eo = res[1]; x.so = res[2]; x.wo = res[3];
    return x;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply one vector after the posedge and queue its expected outputs.
  task automatic apply(string nm, logic r, logic cs, logic [63:0] cc, logic [7:0] n,
                       logic [7:0] e, logic [7:0] s, logic [7:0] w, logic [7:0] xno,
                       logic [7:0] xeo, logic [7:0] xso, logic [7:0] xwo);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; cset = cs; c = cc; ni = n; ei = e; si = s; wi = w;
    x.nm = nm; x.no = xno; x.eo = xeo; x.so = xso; x.wo = xwo;
    sb.push_back(x);
  endtask

  // Monitor: compare whatever the driver queued this cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        chk({x.nm, ".north"}, no, x.no);
        chk({x.nm, ".east"},  eo, x.eo);
        chk({x.nm, ".south"}, so, x.so);
        chk({x.nm, ".west"},  wo, x.wo);
      end
    end
  end

  // Driver.
  initial begin
    rst = 1'b0; cset = 1'b0; c = '0;
    ni = '0; ei = '0; si = '0; wi = '0;

    apply("reset_init",    1'b0, 1'b0, 64'h0, 8'hA5, 8'h3C, 8'hF0, 8'h0F,
          8'h3C, 8'hF0, 8'h0F, 8'hA5);
    apply("cset_code0",    1'b1, 1'b1, 64'h0, 8'hA5, 8'h3C, 8'hF0, 8'h0F,
          8'h3C, 8'hF0, 8'h0F, 8'hA5);
    apply("cset_code2",    1'b1, 1'b1, {8{8'hAA}}, 8'hA5, 8'h3C, 8'hF0, 8'h0F,
          8'h0F, 8'hA5, 8'h3C, 8'hF0);
    apply("track0_off",    1'b1, 1'b1, 64'h0000_0000_0000_00FF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
          8'hFE, 8'hFE, 8'hFE, 8'hFE);
    apply("mixed_codes",   1'b1, 1'b1, {8{8'hE4}}, 8'hA5, 8'h3C, 8'hF0, 8'h0F,
          8'h3C, 8'h0F, 8'h3C, 8'h00);
    apply("load_code1",    1'b1, 1'b1, {8{8'h55}}, 8'hA5, 8'h3C, 8'hF0, 8'h0F,
          8'hF0, 8'h0F, 8'hA5, 8'h3C);
    apply("hold_code1",    1'b1, 1'b0, 64'h0, 8'hA5, 8'h3C, 8'hF0, 8'h0F,
          8'hF0, 8'h0F, 8'hA5, 8'h3C);
    apply("hold_newin",    1'b1, 1'b0, 64'h0, 8'h12, 8'h34, 8'h56, 8'h78,
          8'h56, 8'h78, 8'h12, 8'h34);
    apply("async_clear",   1'b0, 1'b0, 64'h0, 8'h12, 8'h34, 8'h56, 8'h78,
          8'h34, 8'h56, 8'h78, 8'h12);
    apply("cset_in_reset", 1'b0, 1'b1, {8{8'hAA}}, 8'h12, 8'h34, 8'h56, 8'h78,
          8'h78, 8'h12, 8'h34, 8'h56);
    apply("after_reset",   1'b1, 1'b0, {8{8'hFF}}, 8'h12, 8'h34, 8'h56, 8'h78,
          8'h34, 8'h56, 8'h78, 8'h12);

    for (int i = 0; i < 100; i++) begin
      logic [63:0] rc;
      logic [7:0]  rn, re, rs, rw;
      exp_t        x;
      rc = {$urandom, $urandom};
      rn = 8'($urandom); re = 8'($urandom); rs = 8'($urandom); rw = 8'($urandom);
      x = model($sformatf("rand%0d", i), rc, rn, re, rs, rw);
      apply(x.nm, 1'b1, 1'b1, rc, rn, re, rs, rw, x.no, x.eo, x.so, x.wo);
    end

    // Let the monitor drain, bounded.
    for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
